breakpoint_unit: RTL

- Address breakpoint stage directly downstream of a pair of cascaded 74x688 comparators.
- Holds a loadable 16-bit breakpoint address and compares it against the address bus with two comparator_688 instances (low byte gates high byte).
- Consumes the active-low not-equal output. Qualifies it with memory-cycle edges, an arm state and a skip count, and raises a halt request to the processor.
- The halt request has an acknowledge handshake.

---
 rtl/cft_bp_pkg.sv | 12 +
 rtl/comparator_688.sv | 11 +
 rtl/breakpoint_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/cft_bp_pkg.sv
// Shared state encoding and default widths for the address breakpoint unit.
package cft_bp_pkg;

    localparam int AWIDTH_DEF = 16;
    localparam int CWIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/comparator_688.sv
// 8-bit identity comparator modelled on the 74x688: neq is low only when enabled (ng=0) and p==q.
module comparator_688 (
    input  logic [7:0] p,
    input  logic [7:0] q,
    input  logic       ng,
    output logic       neq
);

    assign neq = ng | (p != q);

endmodule

// File: rtl/breakpoint_unit.sv
// Address breakpoint: cascaded byte comparators, cycle-start qualification, skip/hit
// counting and a halt request with acknowledge handshake.
import cft_bp_pkg::*;

module breakpoint_unit #(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int CWIDTH = CWIDTH_DEF
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [AWIDTH-1:0] ab,
    input  logic              nmem,
    input  logic [AWIDTH-1:0] din,
    input  logic              wr_addr,
    input  logic              wr_cnt,
    input  logic              arm,
    input  logic              hack,
    output logic              neq,
    output logic              armed,
    output logic              nhalt,
    output logic [CWIDTH-1:0] hits
);

    localparam int NBYTES = AWIDTH / 8;

    logic [AWIDTH-1:0] bp_addr;
    logic [CWIDTH-1:0] skip;
    logic              nmem_q;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [NBYTES:0]   chain;
    logic              cstart;
    logic              match;
    logic              hit_ev;

    function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Each byte comparator is enabled only when every lower byte already matched.
    assign chain[0] = 1'b0;
    for (genvar g = 0; g < NBYTES; g++) begin : g_cmp
        comparator_688 u_cmp (
            .p  (ab[8*g +: 8]),
            .q  (bp_addr[8*g +: 8]),
            .ng (chain[g]),
            .neq(chain[g+1])
        );
    end
    assign neq = chain[NBYTES];

    // A falling nmem marks one event per bus cycle; gating by cstart keeps an X on ab harmless.
    assign cstart = !nmem && nmem_q;
    assign match  = cstart && !neq;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= ST_IDLE;
            nhalt <= 1'b1;
        end else begin
            state <= state_nxt;
            nhalt <= (state_nxt != ST_HALT);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (arm) state_nxt = ST_ARMED;
            ST_ARMED:   if (match && skip == '0) state_nxt = ST_HALT;
            ST_HALT:    if (hack) state_nxt = ST_RELEASE;
            ST_RELEASE: if (!hack) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        armed  = (state == ST_ARMED);
        hit_ev = (state == ST_ARMED) && match;
    end

    // A register write on the same edge as a decrement takes precedence.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            bp_addr <= '0;
            skip    <= '0;
            hits    <= '0;
            nmem_q  <= 1'b1;
        end else begin
            nmem_q <= nmem;
            if (wr_addr) bp_addr <= din;
            if (wr_cnt) skip <= din[CWIDTH-1:0];
            else if (hit_ev && skip != '0) skip <= skip - 1'b1;
            if (hit_ev) hits <= sat_inc(hits);
        end
    end

endmodule
